// File: rtl/onehot_encoder_q.sv
// rtl/onehot_encoder_q.sv - sticky multi-hot request collector emitting binary indices on a valid/ready stream
// Optional feature: ROUND_ROBIN_EN selects rotating priority instead of fixed lowest-index priority.
module onehot_encoder_q #(
    parameter  int W  = 8,
    localparam int IW = $clog2(W)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [W-1:0]  req_i,
    input  logic          flush_i,
    input  logic          out_ready_i,
    output logic          out_valid_o,
    output logic [IW-1:0] out_idx_o,
    output logic [W-1:0]  pending_o,
    output logic          busy_o
);

    logic [W-1:0]  pending_q, pending_d;
    logic          out_valid_q, out_valid_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic [IW-1:0] sel;
    logic          load;
    logic [W-1:0]  clr_mask;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;
    logic          found;

    // Search starts one past the last served index and wraps around.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < W; i++) begin
            cand = ptr_q + IW'(i);
            if (!found && pending_q[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end
`else
    // Walk downwards so the lowest set bit is the final assignment.
    always_comb begin
        sel = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel = IW'(i);
            end
        end
    end
`endif

    assign load     = (|pending_q) && (!out_valid_q || out_ready_i);
    assign clr_mask = load ? (W'(1) << sel) : '0;

    always_comb begin
        pending_d   = (pending_q & ~clr_mask) | req_i;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = sel;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (flush_i) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
        end
    end

`ifdef ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = sel + IW'(1);
        end
        if (flush_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign pending_o   = pending_q;
    assign busy_o      = (|pending_q) | out_valid_q;

endmodule

// File: tb/tb_onehot_encoder_q.sv
// tb/tb_onehot_encoder_q.sv - table-driven self-checking bench for onehot_encoder_q
module tb_onehot_encoder_q;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       flush;
    logic       out_ready;
    logic       out_valid;
    logic [2:0] out_idx;
    logic [7:0] pending;
    logic       busy;

    int checks;
    int failures;

    typedef struct {
        logic [7:0] req;
        logic       flush;
        logic       rdy;
        logic       ev;
        logic [2:0] eidx;
        logic [7:0] epend;
        logic       ebusy;
    } vec_t;

    vec_t vecs[$];

    onehot_encoder_q #(.W(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .flush_i     (flush),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_idx_o   (out_idx),
        .pending_o   (pending),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic f, input logic rdy);
        req       = r;
        flush     = f;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [2:0] eidx,
                           input logic [7:0] epend, input logic ebusy);
        chk({tag, ".valid"},   32'(out_valid), 32'(ev));
        chk({tag, ".idx"},     32'(out_idx),   32'(eidx));
        chk({tag, ".pending"}, 32'(pending),   32'(epend));
        chk({tag, ".busy"},    32'(busy),      32'(ebusy));
    endtask

    function automatic vec_t mk(logic [7:0] r, logic f, logic rdy, logic ev,
                                logic [2:0] eidx, logic [7:0] epend, logic ebusy);
        vec_t v;
        v.req = r; v.flush = f; v.rdy = rdy;
        v.ev = ev; v.eidx = eidx; v.epend = epend; v.ebusy = ebusy;
        return v;
    endfunction

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;

        // single request
        vecs.push_back(mk(8'h10, 0, 1, 0, 3'd0, 8'h10, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd4, 8'h00, 1));
        vecs.push_back(mk(8'h00, 0, 1, 0, 3'd4, 8'h00, 0));
        vecs.push_back(mk(8'h00, 1, 1, 0, 3'd4, 8'h00, 0));
        // multi-hot, priority order 0,2,5,7
        vecs.push_back(mk(8'hA5, 0, 1, 0, 3'd4, 8'hA5, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd0, 8'hA4, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd2, 8'hA0, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd5, 8'h80, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd7, 8'h00, 1));
        vecs.push_back(mk(8'h00, 0, 1, 0, 3'd7, 8'h00, 0));
        vecs.push_back(mk(8'h00, 1, 1, 0, 3'd7, 8'h00, 0));
        // backpressure
        vecs.push_back(mk(8'h06, 0, 0, 0, 3'd7, 8'h06, 1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 3'd1, 8'h04, 1));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(8'h00, 0, 0, 1, 3'd1, 8'h04, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd2, 8'h00, 1));
        vecs.push_back(mk(8'h00, 0, 1, 0, 3'd2, 8'h00, 0));
        vecs.push_back(mk(8'h00, 1, 1, 0, 3'd2, 8'h00, 0));
        // re-request of the index in the output register, then set-wins on same-edge load
        vecs.push_back(mk(8'h08, 0, 1, 0, 3'd2, 8'h08, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd3, 8'h00, 1));
        vecs.push_back(mk(8'h08, 0, 1, 0, 3'd3, 8'h08, 1));
        vecs.push_back(mk(8'h08, 0, 1, 1, 3'd3, 8'h08, 1));
        vecs.push_back(mk(8'h00, 0, 1, 1, 3'd3, 8'h00, 1));
        vecs.push_back(mk(8'h00, 0, 1, 0, 3'd3, 8'h00, 0));
        vecs.push_back(mk(8'h00, 1, 1, 0, 3'd3, 8'h00, 0));
        // flush overrides req and load
        vecs.push_back(mk(8'hFF, 0, 0, 0, 3'd3, 8'hFF, 1));
        vecs.push_back(mk(8'h00, 0, 0, 1, 3'd0, 8'hFE, 1));
        vecs.push_back(mk(8'hFF, 0, 0, 1, 3'd0, 8'hFF, 1));
        vecs.push_back(mk(8'h01, 1, 1, 0, 3'd0, 8'h00, 0));
        vecs.push_back(mk(8'h00, 0, 1, 0, 3'd0, 8'h00, 0));

        #1;
        chk_all("reset", 0, 3'd0, 8'h00, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].flush, vecs[i].rdy);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eidx, vecs[i].epend, vecs[i].ebusy);
        end

        // asynchronous reset mid-stream
        step(8'hA5, 0, 1);
        chk("pre_rst.pending", 32'(pending), 32'hA5);
        step(8'h00, 0, 1);
        chk("pre_rst.valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 3'd0, 8'h00, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(8'h00, 0, 1);
        chk_all("post_rst", 0, 3'd0, 8'h00, 0);

`ifdef ROUND_ROBIN_EN
        step(8'h81, 0, 1);
        step(8'h01, 0, 1);
        chk("rr.first", 32'(out_idx), 32'd0);
        step(8'h01, 0, 1);
        chk("rr.second", 32'(out_idx), 32'd7);
        step(8'h01, 0, 1);
        chk("rr.third", 32'(out_idx), 32'd0);
        step(8'h00, 1, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
